// File: rtl/ecg_pt_feature_axis.sv
// Pan-Tompkins feature stage: 5-point derivative, squaring, moving-window integration (MWI_WARMUP_EN gates early output).
// Latency: 3 registered stages (derivative, square, MWI sum); throughput one sample per clock.
// Backpressure: all stages advance together only when the output slot is empty or being taken.
`timescale 1ns/1ps
module ecg_pt_feature_axis #(
    parameter int inout_width = 16,
    parameter int sq_shift    = 15,
    parameter int mwi_len     = 75,
    parameter int sq_width    = 16,
    parameter int out_width   = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic signed [inout_width-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [out_width-1:0]          m_axis_tdata
);

    localparam int DW    = inout_width + 3;
    localparam int PRODW = 2 * inout_width;
    localparam int PW    = (mwi_len > 1) ? $clog2(mwi_len) : 1;

    function automatic logic signed [DW-1:0] sx(input logic signed [inout_width-1:0] v);
        return {{3{v[inout_width-1]}}, v};
    endfunction

    logic                          w_advance;
    logic                          w_accept;
    logic                          w_present;
    logic signed [DW-1:0]          w_dsum;
    logic signed [inout_width-1:0] w_d;
    logic signed [PRODW-1:0]       w_d_ext;
    logic signed [PRODW-1:0]       w_prod;
    logic [sq_width-1:0]           w_q;
    logic [out_width-1:0]          w_sum_next;

    logic signed [inout_width-1:0] r_x1, r_x2, r_x3, r_x4;
    logic signed [inout_width-1:0] r_d;
    logic [sq_width-1:0]           r_q;
    logic [sq_width-1:0]           r_buf [mwi_len];
    logic [PW-1:0]                 r_ptr;
    logic [out_width-1:0]          r_sum;
    logic                          r_s1_vld;
    logic                          r_s2_vld;
    logic                          r_m_vld;

    assign w_advance     = !r_m_vld || m_axis_tready;
    assign w_accept      = s_axis_tvalid && w_advance;
    assign s_axis_tready = w_advance;
    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tdata  = r_sum;

    assign w_dsum     = (sx(s_axis_tdata) <<< 1) + sx(r_x1) - sx(r_x3) - (sx(r_x4) <<< 1);
    assign w_d        = inout_width'(w_dsum >>> 3);
    assign w_d_ext    = {{inout_width{r_d[inout_width-1]}}, r_d};
    assign w_prod     = w_d_ext * w_d_ext;
    assign w_q        = sq_width'($unsigned(w_prod) >> sq_shift);
    assign w_sum_next = r_sum + out_width'(r_q) - out_width'(r_buf[r_ptr]);

`ifdef MWI_WARMUP_EN
    // Saturating count of S3 results; output stays hidden until the window has fully primed.
    localparam int WARM_N = (mwi_len + 4 > 255) ? 255 : mwi_len + 4;
    logic [7:0] r_warm;
    assign w_present = (r_warm >= 8'(WARM_N));
`else
    assign w_present = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x1     <= '0;
            r_x2     <= '0;
            r_x3     <= '0;
            r_x4     <= '0;
            r_d      <= '0;
            r_q      <= '0;
            r_ptr    <= '0;
            r_sum    <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_m_vld  <= 1'b0;
            for (int i = 0; i < mwi_len; i++) begin
                r_buf[i] <= '0;
            end
`ifdef MWI_WARMUP_EN
            r_warm   <= '0;
`endif
        end else if (w_advance) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_d  <= w_d;
                r_x1 <= s_axis_tdata;
                r_x2 <= r_x1;
                r_x3 <= r_x2;
                r_x4 <= r_x3;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_q <= w_q;
            end
            // Bubbles leave the ring buffer, pointer and running sum untouched.
            r_m_vld <= r_s2_vld && w_present;
            if (r_s2_vld) begin
                r_sum        <= w_sum_next;
                r_buf[r_ptr] <= r_q;
                r_ptr        <= (r_ptr == PW'(mwi_len - 1)) ? '0 : r_ptr + 1'b1;
`ifdef MWI_WARMUP_EN
                if (r_warm != 8'hFF) begin
                    r_warm <= r_warm + 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ecg_pt_feature_axis.sv
// Directed bench for ecg_pt_feature_axis: reset, step, backpressure, throughput, mid-run reset + impulse.
`timescale 1ns/1ps
module tb_ecg_pt_feature_axis;

    localparam int IW       = 16;
    localparam int SQ_SHIFT = 15;
    localparam int MWI_LEN  = 75;
    localparam int SQ_W     = 16;
    localparam int OUT_W    = 24;
    localparam longint MAX_SUM = longint'(MWI_LEN) * ((longint'(1) << SQ_W) - 1);

    if (MAX_SUM >= (longint'(1) << OUT_W)) begin : g_sum_width_check
        $error("MWI sum width too small for mwi_len * max square");
    end

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_vld = 1'b0;
    logic             s_rdy;
    logic [IW-1:0]    s_dat = '0;
    logic             m_vld;
    logic             m_rdy = 1'b1;
    logic [OUT_W-1:0] m_dat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int out_q[$];
    int outc_q[$];
    int acc_q[$];

    always #5 clk = ~clk;

    ecg_pt_feature_axis #(
        .inout_width(IW),
        .sq_shift   (SQ_SHIFT),
        .mwi_len    (MWI_LEN),
        .sq_width   (SQ_W),
        .out_width  (OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tvalid(s_vld),
        .s_axis_tready(s_rdy),
        .s_axis_tdata (s_dat),
        .m_axis_tvalid(m_vld),
        .m_axis_tready(m_rdy),
        .m_axis_tdata (m_dat)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && s_vld && s_rdy) acc_q.push_back(cyc);
        if (rst_n && m_vld && m_rdy) begin
            out_q.push_back(int'(m_dat));
            outc_q.push_back(cyc);
        end
    end

    function automatic int step_exp(input int i);
        if (i == 0) return 1;
        if (i == 1) return 5;
        if (i == 2) return 9;
        if (i <= 74) return 10;
        if (i == 75) return 9;
        if (i == 76) return 5;
        if (i == 77) return 1;
        return 0;
    endfunction

    function automatic int imp_exp(input int i);
        case (i)
            0: return 2048;
            1: return 2560;
            2: return 2560;
            3: return 3072;
            default: return 5120;
        endcase
    endfunction

    task automatic clear_q();
        out_q.delete();
        outc_q.delete();
        acc_q.delete();
    endtask

    task automatic send(input logic [IW-1:0] v);
        @(negedge clk);
        s_vld = 1'b1;
        s_dat = v;
        for (int t = 0; t < 100; t++) begin
            #4;
            if (s_rdy) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: s_axis_tready stayed 0 for 100 cycles, required 1");
    endtask

    task automatic end_stream();
        @(negedge clk);
        s_vld = 1'b0;
        s_dat = '0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        for (int t = 0; t < 300 && out_q.size() < n; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (out_q.size() !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs, expected %0d", name, out_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_rdy = 1'b1;
        clear_q();
    endtask

    task automatic check_step_values(input string name);
        for (int i = 0; i < out_q.size() && i < 100; i++) begin
            checks++;
            if (out_q[i] !== step_exp(i)) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d, expected %0d", name, i, out_q[i], step_exp(i));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_vld = 1'($urandom);
            s_dat = IW'($urandom);
            m_rdy = 1'($urandom);
            #1;
            checks++;
            if (m_vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_tvalid: got %b, expected 0", m_vld);
            end
            checks++;
            if (m_dat !== '0) begin
                errors++;
                $display("FAIL reset_tdata: got %0d, expected 0", m_dat);
            end
        end
        @(negedge clk);
        s_vld = 1'b0;
        s_dat = '0;
        m_rdy = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (s_rdy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_tready: got %b, expected 1", s_rdy);
        end
        checks++;
        if (m_vld !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tvalid: got %b, expected 0", m_vld);
        end
        clear_q();
    endtask

    task automatic test_step_throughput();
        clear_q();
        for (int i = 0; i < 100; i++) send(16'd1000);
        end_stream();
        wait_outputs(100, "step");
        check_step_values("step");
        checks++;
        if (acc_q.size() < 1 || outc_q.size() < 1) begin
            errors++;
            $display("FAIL latency: got %0d accepts / %0d outputs, expected nonzero", acc_q.size(), outc_q.size());
        end else if (outc_q[0] - acc_q[0] !== 3) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected 3", outc_q[0] - acc_q[0]);
        end
        for (int i = 1; i < outc_q.size(); i++) begin
            checks++;
            if (outc_q[i] - outc_q[i-1] !== 1) begin
                errors++;
                $display("FAIL gap[%0d]: got spacing %0d, expected 1", i, outc_q[i] - outc_q[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        do_reset();
        fork
            begin
                for (int i = 0; i < 100; i++) send(16'd1000);
                end_stream();
            end
            begin
                repeat (30) @(negedge clk);
                m_rdy = 1'b0;
                #1;
                held = m_dat;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    #1;
                    checks++;
                    if (s_rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_tready[%0d]: got %b, expected 0", k, s_rdy);
                    end
                    checks++;
                    if (m_dat !== held) begin
                        errors++;
                        $display("FAIL stall_tdata[%0d]: got %0d, expected %0d", k, m_dat, held);
                    end
                end
                m_rdy = 1'b1;
            end
        join
        wait_outputs(100, "bp");
        check_step_values("bp");
    endtask

    task automatic test_midrun_reset_impulse();
        m_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(16'd1000);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tvalid: got %b, expected 0", m_vld);
        end
        checks++;
        if (m_dat !== '0) begin
            errors++;
            $display("FAIL midrst_tdata: got %0d, expected 0", m_dat);
        end
        s_vld = 1'b0;
        s_dat = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        send(16'h8000);
        for (int i = 0; i < 9; i++) send(16'd0);
        end_stream();
        wait_outputs(10, "impulse");
        for (int i = 0; i < out_q.size() && i < 10; i++) begin
            checks++;
            if (out_q[i] !== imp_exp(i)) begin
                errors++;
                $display("FAIL impulse[%0d]: got %0d, expected %0d", i, out_q[i], imp_exp(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_throughput();
        test_backpressure();
        test_midrun_reset_impulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
